// File: rtl/display_bcd_ctrl.sv
// Six-digit display controller: binary-to-BCD via iterative double-dabble,
// with leading-zero blanking, live digit mask and overflow saturation.
module display_bcd_ctrl #(
    parameter int unsigned BIN_W   = 20,
    parameter int unsigned MAX_VAL = 999999
) (
    input  logic             clk,
    input  logic             rst_N,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             blank_lz,
    input  logic [5:0]       digit_mask,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [5:0]       enable,
    output logic [23:0]      number_BCD
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        UPDATE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [BIN_W-1:0]   bin_sh;
    logic [23:0]        bcd;
    logic [23:0]        bcd_adj;
    logic [CNT_W-1:0]   cnt;
    logic               lz_cap;
    logic               ovf_cap;
    logic               done_q;
    logic               ovf_q;
    logic [5:0]         en_reg;
    logic [5:0]         en_calc;
    logic [23:0]        number_q;
    logic               seen;
    int unsigned        idx;

    // State register
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CONV;
            CONV:    if (cnt == CNT_W'(1)) state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy       = (state != IDLE);
        done       = done_q;
        ovf        = ovf_q;
        number_BCD = number_q;
        enable     = en_reg & digit_mask;
    end

    always_comb begin
        bcd_adj = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3
                                                         : bcd[4*i +: 4];
        end
    end

    // Digits from the most significant nonzero one down to digit 0 stay lit
    always_comb begin
        en_calc = '0;
        seen    = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < 6; i++) begin
            idx          = 5 - i;
            seen         = seen | (bcd[4*idx +: 4] != 4'd0);
            en_calc[idx] = seen;
        end
        en_calc[0] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            bin_sh   <= '0;
            bcd      <= '0;
            cnt      <= '0;
            lz_cap   <= 1'b0;
            ovf_cap  <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            en_reg   <= '0;
            number_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sh  <= bin_in;
                        lz_cap  <= blank_lz;
                        ovf_cap <= ({{(32-BIN_W){1'b0}}, bin_in} > 32'(MAX_VAL));
                        bcd     <= '0;
                        cnt     <= CNT_W'(BIN_W);
                    end
                end
                CONV: begin
                    {bcd, bin_sh} <= {bcd_adj, bin_sh} << 1;
                    cnt           <= cnt - CNT_W'(1);
                end
                UPDATE: begin
                    number_q <= ovf_cap ? 24'h999999 : bcd;
                    ovf_q    <= ovf_cap;
                    en_reg   <= (!lz_cap || ovf_cap) ? '1 : en_calc;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_display_bcd_ctrl.sv
// Directed bench for display_bcd_ctrl: conversions, blanking, mask, saturation,
// busy-start rejection, done-cycle restart and asynchronous abort.
module tb_display_bcd_ctrl;

    logic        clk;
    logic        rst_N;
    logic        start;
    logic [19:0] bin_in;
    logic        blank_lz;
    logic [5:0]  digit_mask;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [5:0]  enable;
    logic [23:0] number_BCD;

    int vectors;
    int miscompares;
    int n;
    int dcount;

    display_bcd_ctrl #(.BIN_W(20), .MAX_VAL(999999)) dut (
        .clk        (clk),
        .rst_N      (rst_N),
        .start      (start),
        .bin_in     (bin_in),
        .blank_lz   (blank_lz),
        .digit_mask (digit_mask),
        .busy       (busy),
        .done       (done),
        .ovf        (ovf),
        .enable     (enable),
        .number_BCD (number_BCD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept a conversion, then wait (bounded) for done; leaves time in the done cycle
    task automatic conv(input logic [19:0] v, input logic lz, output int cyc);
        bin_in   = v;
        blank_lz = lz;
        start    = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        cyc = 0;
        while (!done && cyc < 60) begin
            step();
            cyc++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_N       = 1'b0;
        start       = 1'b0;
        bin_in      = '0;
        blank_lz    = 1'b0;
        digit_mask  = 6'h3F;
        step();
        step();
        check("rst_busy",   32'(busy),       32'd0);
        check("rst_done",   32'(done),       32'd0);
        check("rst_ovf",    32'(ovf),        32'd0);
        check("rst_number", 32'(number_BCD), 32'h000000);
        check("rst_enable", 32'(enable),     32'h00);
        rst_N = 1'b1;
        step();

        conv(20'd123456, 1'b0, n);
        check("lat_123456",  32'(n),          32'd21);
        check("num_123456",  32'(number_BCD), 32'h123456);
        check("en_123456",   32'(enable),     32'h3F);
        check("ovf_123456",  32'(ovf),        32'd0);
        step();
        check("done_single", 32'(done),       32'd0);

        conv(20'd42, 1'b1, n);
        check("num_42", 32'(number_BCD), 32'h000042);
        check("en_42",  32'(enable),     32'h03);
        step();
        digit_mask = 6'b111110;
        #1;
        check("mask_live", 32'(enable), 32'h02);
        dcount = 0;
        repeat (5) begin
            step();
            if (done) dcount++;
        end
        check("mask_no_done", 32'(dcount), 32'd0);
        digit_mask = 6'h3F;

        conv(20'd0, 1'b1, n);
        check("num_0", 32'(number_BCD), 32'h000000);
        check("en_0",  32'(enable),     32'h01);
        conv(20'd999999, 1'b1, n);
        check("num_max", 32'(number_BCD), 32'h999999);
        check("ovf_max", 32'(ovf),        32'd0);
        check("en_max",  32'(enable),     32'h3F);

        conv(20'd1000000, 1'b1, n);
        check("num_sat", 32'(number_BCD), 32'h999999);
        check("ovf_sat", 32'(ovf),        32'd1);
        check("en_sat",  32'(enable),     32'h3F);
        conv(20'd7, 1'b1, n);
        check("num_7", 32'(number_BCD), 32'h000007);
        check("ovf_7", 32'(ovf),        32'd0);
        check("en_7",  32'(enable),     32'h01);
        step();

        // Start 500, then a stray start at cycle 5 that must be dropped
        bin_in   = 20'd500;
        blank_lz = 1'b0;
        start    = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        bin_in = 20'd777;
        start  = 1'b1;
        step();
        start = 1'b0;
        n = 5;
        while (!done && n < 60) begin
            step();
            n++;
        end
        check("lat_500", 32'(n),          32'd21);
        check("num_500", 32'(number_BCD), 32'h000500);
        dcount = 0;
        repeat (25) begin
            step();
            if (done || busy) dcount++;
        end
        check("no_queued_start", 32'(dcount), 32'd0);

        conv(20'd321, 1'b0, n);
        check("num_321", 32'(number_BCD), 32'h000321);
        conv(20'd777, 1'b0, n);
        check("lat_777_on_done", 32'(n),          32'd21);
        check("num_777",         32'(number_BCD), 32'h000777);
        step();

        bin_in = 20'd654321;
        start  = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        #2;
        rst_N = 1'b0;
        #1;
        check("abort_busy",   32'(busy),       32'd0);
        check("abort_done",   32'(done),       32'd0);
        check("abort_ovf",    32'(ovf),        32'd0);
        check("abort_number", 32'(number_BCD), 32'h000000);
        check("abort_enable", 32'(enable),     32'h00);
        step();
        rst_N = 1'b1;
        dcount = 0;
        repeat (25) begin
            step();
            if (done || busy) dcount++;
        end
        check("abort_no_done", 32'(dcount),     32'd0);
        check("abort_blank",   32'(number_BCD), 32'h000000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
